// File: rtl/anita3_event_readout.sv
// Event buffer readout for clk33: header beat, credit-limited word reads through a
// 2-entry skid FIFO onto a valid/ready stream, then buffer release and CDC holdoff.
module anita3_event_readout #(
    parameter int unsigned EVT_WORDS = 64,
    parameter int unsigned HOLDOFF   = 8,
    parameter logic [7:0]  MAGIC     = 8'hE5
) (
    input  logic        clk33_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        evt_ready_i,
    output logic [5:0]  event_addr_o,
    input  logic [31:0] event_dat_i,
    output logic [31:0] m_tdata_o,
    output logic        m_tvalid_o,
    input  logic        m_tready_i,
    output logic        m_tlast_o,
    output logic        clr_evt_o,
    output logic [15:0] evt_count_o,
    output logic        busy_o
);
    // state    | meaning
    // S_IDLE   | waiting for enable_i && evt_ready_i
    // S_HEADER | push header beat, issue read of word 0
    // S_READ   | issue remaining reads as credit allows
    // S_DRAIN  | wait for FIFO empty and no read in flight
    // S_CLEAR  | clr_evt_o high for this one cycle
    // S_HOLD   | ignore evt_ready_i for HOLDOFF cycles
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_READ, S_DRAIN, S_CLEAR, S_HOLD} state_t;

    localparam logic [6:0] LP_LAST_IDX = 7'(EVT_WORDS - 1);
    localparam logic [7:0] LP_WORDS8   = 8'(EVT_WORDS);
    localparam logic [7:0] LP_HOLD_LD  = 8'(HOLDOFF - 1);

    state_t      r_state;
    logic [6:0]  r_idx;
    logic [5:0]  r_addr_last;
    logic        r_inflight;
    logic        r_inflight_last;
    logic [32:0] r_fifo [2];
    logic        r_wp;
    logic        r_rp;
    logic [1:0]  r_cnt;
    logic [7:0]  r_timer;
    logic        r_clr;
    logic        r_busy;
    logic [15:0] r_evt_count;

    logic        w_hdr_push;
    logic        w_push;
    logic        w_pop;
    logic [32:0] w_push_data;
    logic [2:0]  w_fill;
    logic        w_issue;
    logic        w_drain_done;

    // Occupancy after this edge, counting the word landing from the read issued last cycle.
    assign w_hdr_push   = (r_state == S_HEADER);
    assign w_pop        = (r_cnt != 2'd0) && m_tready_i;
    assign w_push       = w_hdr_push || r_inflight;
    assign w_push_data  = w_hdr_push ? {1'b0, MAGIC, r_evt_count, LP_WORDS8}
                                     : {r_inflight_last, event_dat_i};
    assign w_fill       = {1'b0, r_cnt} + {2'b0, r_inflight} + {2'b0, w_hdr_push} - {2'b0, w_pop};
    assign w_issue      = ((r_state == S_HEADER) || (r_state == S_READ)) && (w_fill < 3'd2);
    assign w_drain_done = (r_state == S_DRAIN) && (r_cnt == 2'd0) && !r_inflight;

    assign event_addr_o = w_issue ? r_idx[5:0] : r_addr_last;
    assign m_tvalid_o   = (r_cnt != 2'd0);
    assign m_tdata_o    = r_fifo[r_rp][31:0];
    assign m_tlast_o    = r_fifo[r_rp][32];
    assign clr_evt_o    = r_clr;
    assign evt_count_o  = r_evt_count;
    assign busy_o       = r_busy;

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_cnt     <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= w_push_data;
                r_wp         <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_addr_last     <= 6'd0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_idx == LP_LAST_IDX);
            if (w_issue) begin
                r_addr_last <= r_idx[5:0];
            end
        end
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_idx       <= 7'd0;
            r_timer     <= 8'd0;
            r_clr       <= 1'b0;
            r_busy      <= 1'b0;
            r_evt_count <= 16'd0;
        end else begin
            r_clr       <= 1'b0;
            r_evt_count <= r_evt_count + {15'd0, w_drain_done};
            case (r_state)
                S_IDLE: begin
                    r_idx <= 7'd0;
                    if (enable_i && evt_ready_i) begin
                        r_state <= S_HEADER;
                        r_busy  <= 1'b1;
                    end
                end
                S_HEADER, S_READ: begin
                    if (w_issue) begin
                        r_idx   <= r_idx + 7'd1;
                        r_state <= (r_idx == LP_LAST_IDX) ? S_DRAIN : S_READ;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= S_CLEAR;
                        r_clr   <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_HOLD;
                    r_timer <= LP_HOLD_LD;
                end
                S_HOLD: begin
                    if (r_timer == 8'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_anita3_event_readout.sv
// Directed bench for anita3_event_readout: cycle-exact first event, random backpressure,
// back-to-back events, enable gating, mid-event reset and event counter wrap.
module tb_anita3_event_readout;
    localparam int EW = 64;
    localparam int HO = 8;

    logic        clk33_i     = 1'b0;
    logic        rst_n_i     = 1'b0;
    logic        enable_i    = 1'b0;
    logic        evt_ready_i = 1'b0;
    logic        m_tready_i  = 1'b0;
    logic [31:0] event_dat_i = 32'd0;
    logic [5:0]  event_addr_o;
    logic [31:0] m_tdata_o;
    logic        m_tvalid_o;
    logic        m_tlast_o;
    logic        clr_evt_o;
    logic [15:0] evt_count_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int clr_cnt = 0;
    logic [32:0] beats[$];
    int hdr_cycs[$];
    int clr_cycs[$];
    logic [32:0] held;
    bit hold_pending = 0;

    anita3_event_readout #(.EVT_WORDS(EW), .HOLDOFF(HO), .MAGIC(8'hE5)) dut (
        .clk33_i(clk33_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .evt_ready_i(evt_ready_i),
        .event_addr_o(event_addr_o), .event_dat_i(event_dat_i),
        .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
        .m_tlast_o(m_tlast_o), .clr_evt_o(clr_evt_o), .evt_count_o(evt_count_o), .busy_o(busy_o)
    );

    always #5 clk33_i = ~clk33_i;

    // Event buffer model: memory[i] = i, one cycle read latency.
    always @(posedge clk33_i) event_dat_i <= {26'd0, event_addr_o};

    always @(negedge clk33_i) begin
        cyc++;
        if (!rst_n_i) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                checks++;
                assert ({m_tlast_o, m_tdata_o} === held) else begin
                    errors++;
                    $error("FAIL stall_stable observed=%h expected=%h", {m_tlast_o, m_tdata_o}, held);
                end
            end
            if (m_tvalid_o && m_tready_i) begin
                beats.push_back({m_tlast_o, m_tdata_o});
                if (m_tdata_o[31:24] == 8'hE5) hdr_cycs.push_back(cyc);
                hold_pending = 0;
            end else if (m_tvalid_o) begin
                hold_pending = 1;
                held = {m_tlast_o, m_tdata_o};
            end else begin
                hold_pending = 0;
            end
            if (clr_evt_o) begin
                clr_cnt++;
                clr_cycs.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk33_i);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 200) begin
            step();
            n++;
        end
        chk({tag, " idle_timeout"}, 64'(busy_o), 64'd0);
    endtask

    task automatic start_evt();
        enable_i    = 1'b1;
        evt_ready_i = 1'b1;
        step();
        evt_ready_i = 1'b0;
    endtask

    task automatic run_event(input bit rnd, input string tag);
        int start = clr_cnt;
        int n = 0;
        while (clr_cnt == start && n < 3000) begin
            step();
            if (rnd) m_tready_i = ($urandom_range(0, 9) >= 3);
            n++;
        end
        m_tready_i = 1'b1;
        chk({tag, " clr_timeout"}, 64'(clr_cnt != start), 64'd1);
    endtask

    task automatic chk_event(input string tag, input int base, input logic [15:0] cnt);
        int bad = 0;
        logic [32:0] e;
        chk({tag, " len"}, 64'(beats.size() >= base + EW + 1), 64'd1);
        for (int i = 0; i < EW + 1 && base + i < beats.size(); i++) begin
            if (i == 0) e = {1'b0, 8'hE5, cnt, 8'(EW)};
            else e = {(i == EW), 32'(i - 1)};
            if (beats[base + i] !== e) bad++;
        end
        chk({tag, " beats"}, 64'(bad), 64'd0);
    endtask

    task automatic wait_beats(input int target, input string tag);
        int n = 0;
        while (beats.size() < target && n < 500) begin
            step();
            n++;
        end
        chk({tag, " beat_timeout"}, 64'(beats.size() >= target), 64'd1);
    endtask

    initial begin
        int c0;
        // Reset state
        repeat (3) step();
        chk("rst_outputs", {m_tvalid_o, m_tlast_o, clr_evt_o, busy_o, event_addr_o, evt_count_o, m_tdata_o},
            64'd0);
        rst_n_i = 1'b1;

        // 1: cycle-exact event with ready held high
        m_tready_i = 1'b1;
        start_evt();
        chk("t1 hdr_pending", {m_tvalid_o, busy_o}, 64'b01);
        step();
        chk("t1 header", {m_tvalid_o, m_tlast_o, m_tdata_o}, {2'b10, 32'hE500_0040});
        for (int i = 0; i < EW; i++) begin
            step();
            chk($sformatf("t1 word%0d", i), {m_tvalid_o, m_tlast_o, m_tdata_o}, {1'b1, (i == EW - 1), 32'(i)});
        end
        step();
        chk("t1 drain", {m_tvalid_o, clr_evt_o}, 64'b00);
        step();
        chk("t1 clr", {clr_evt_o, evt_count_o}, {1'b1, 16'd1});
        step();
        chk("t1 clr_once", {clr_evt_o, busy_o}, 64'b01);
        chk_event("t1", 0, 16'd0);
        chk("t1 clr_count", 64'(clr_cnt), 64'd1);

        // 2: same event under random backpressure
        wait_idle("t2");
        beats.delete();
        start_evt();
        run_event(1'b1, "t2");
        chk_event("t2", 0, 16'd1);
        chk("t2 count", 64'(evt_count_o), 64'd2);

        // 3: evt_ready held high across three events, fresh counter
        wait_idle("t3");
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        beats.delete();
        hdr_cycs.delete();
        clr_cycs.delete();
        enable_i    = 1'b1;
        evt_ready_i = 1'b1;
        run_event(1'b0, "t3a");
        run_event(1'b0, "t3b");
        run_event(1'b0, "t3c");
        evt_ready_i = 1'b0;
        chk_event("t3a", 0, 16'd0);
        chk_event("t3b", EW + 1, 16'd1);
        chk_event("t3c", 2 * (EW + 1), 16'd2);
        chk("t3 gap1", 64'((hdr_cycs.size() > 2) && (clr_cycs.size() > 1) && (hdr_cycs[1] - clr_cycs[0] > HO)), 64'd1);
        chk("t3 gap2", 64'((hdr_cycs.size() > 2) && (clr_cycs.size() > 1) && (hdr_cycs[2] - clr_cycs[1] > HO)), 64'd1);

        // 4: enable gating, then enable dropped mid-event
        wait_idle("t4");
        beats.delete();
        enable_i    = 1'b0;
        evt_ready_i = 1'b1;
        repeat (20) step();
        chk("t4 gated", {m_tvalid_o, busy_o, 32'(beats.size())}, 64'd0);
        enable_i = 1'b1;
        wait_beats(11, "t4");
        enable_i = 1'b0;
        run_event(1'b0, "t4");
        evt_ready_i = 1'b0;
        chk_event("t4", 0, 16'd3);
        chk("t4 count", 64'(evt_count_o), 64'd4);

        // 5: asynchronous reset mid-event
        wait_idle("t5");
        beats.delete();
        start_evt();
        wait_beats(21, "t5");
        c0 = clr_cnt;
        #2 rst_n_i = 1'b0;
        #1;
        chk("t5 async_rst", {m_tvalid_o, m_tlast_o, clr_evt_o, busy_o, event_addr_o, evt_count_o, m_tdata_o},
            64'd0);
        repeat (3) step();
        rst_n_i = 1'b1;
        step();
        chk("t5 no_clr", 64'(clr_cnt), 64'(c0));
        beats.delete();
        start_evt();
        run_event(1'b0, "t5");
        chk_event("t5", 0, 16'd0);

        // 6: counter wrap
        wait_idle("t6");
        force dut.r_evt_count = 16'hFFFF;
        step();
        step();
        release dut.r_evt_count;
        step();
        chk("t6 preload", 64'(evt_count_o), 64'hFFFF);
        beats.delete();
        start_evt();
        run_event(1'b0, "t6a");
        chk_event("t6a", 0, 16'hFFFF);
        chk("t6 wrap", 64'(evt_count_o), 64'd0);
        wait_idle("t6b");
        beats.delete();
        start_evt();
        run_event(1'b0, "t6b");
        chk_event("t6b", 0, 16'd0);
        chk("t6 after_wrap", 64'(evt_count_o), 64'd1);

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
